// File: rtl/dma_ext_mem_responder_if.sv
// DMA-side read/write bus for the external-memory responder.
// The master modport is the DMA side; the slave modport is the memory side.
interface dma_ext_mem_responder_if;
  logic        rd_req_i;
  logic        wr_req_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        err_o;
  logic [15:0] rd_count_o;
  logic [15:0] wr_count_o;

  modport master (
    output rd_req_i, wr_req_i, addr_i, wr_data_i,
    input  rd_data_o, rd_valid_o, err_o, rd_count_o, wr_count_o
  );

  modport slave (
    input  rd_req_i, wr_req_i, addr_i, wr_data_i,
    output rd_data_o, rd_valid_o, err_o, rd_count_o, wr_count_o
  );
endinterface

// File: rtl/dma_ext_mem_responder.sv
// Word-array memory behind the DMA read/write port.
// Reads return after a fixed latency; writes commit at the request edge.
module dma_ext_mem_responder #(
  parameter int          DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input logic                    clk,
  input logic                    rst,
  dma_ext_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  logic [31:0]      mem [DEPTH];
  logic [31:0]      off;
  logic             in_win;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;

  logic             vld_p   [RD_LATENCY];
  logic [31:0]      dat_p   [RD_LATENCY];
  logic             vld_nxt [RD_LATENCY];
  logic [31:0]      dat_nxt [RD_LATENCY];

  logic             err;
  logic [15:0]      rd_count;
  logic [15:0]      wr_count;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of the window.
  always_comb begin
    off     = bus.addr_i - BASE_ADDR;
    in_win  = off < WIN_BYTES;
    idx     = off[IDX_W+1:2];
    rd_word = ERR_DATA;
    if (in_win) rd_word = bus.wr_req_i ? bus.wr_data_i : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.wr_req_i && in_win) mem[idx] <= bus.wr_data_i;
  end

  // Stage 0 captures the array at the accept edge; later stages only shift.
  always_comb begin
    vld_nxt[0] = bus.rd_req_i;
    dat_nxt[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_nxt[i] = vld_p[i-1];
      dat_nxt[i] = dat_p[i-1];
    end
  end

  // Last data stage is the output register and holds between valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
      dat_p[RD_LATENCY-1] <= '0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= vld_nxt[i];
      if (vld_nxt[RD_LATENCY-1]) dat_p[RD_LATENCY-1] <= dat_nxt[RD_LATENCY-1];
    end
    for (int i = 0; i < RD_LATENCY - 1; i++) dat_p[i] <= dat_nxt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if ((bus.rd_req_i || bus.wr_req_i) && !in_win) err <= 1'b1;
      if (bus.rd_req_i) rd_count <= sat_inc(rd_count);
      if (bus.wr_req_i) wr_count <= sat_inc(wr_count);
    end
  end

  assign bus.rd_valid_o = vld_p[RD_LATENCY-1];
  assign bus.rd_data_o  = dat_p[RD_LATENCY-1];
  assign bus.err_o      = err;
  assign bus.rd_count_o = rd_count;
  assign bus.wr_count_o = wr_count;
endmodule

// File: tb/tb_dma_ext_mem_responder.sv
// Bench for dma_ext_mem_responder: three instances (latency 2, 1, 8) share one
// stimulus stream; each has its own scoreboard of expected read beats.
module tb_dma_ext_mem_responder;
  localparam int          LAT [3] = '{2, 1, 8};
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  exp_t        sb [3][$];
  exp_t        e_m;
  logic [31:0] mdl [256];
  logic [15:0] exp_rd = '0;
  logic [15:0] exp_wr = '0;
  logic        exp_err = 1'b0;

  logic        vld_w [3];
  logic [31:0] dat_w [3];
  logic        err_w [3];
  logic [15:0] rdc_w [3];
  logic [15:0] wrc_w [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_ext_mem_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].rd_req_i  = rd_req;
    assign bus[g].wr_req_i  = wr_req;
    assign bus[g].addr_i    = addr;
    assign bus[g].wr_data_i = wr_data;
    assign vld_w[g] = bus[g].rd_valid_o;
    assign dat_w[g] = bus[g].rd_data_o;
    assign err_w[g] = bus[g].err_o;
    assign rdc_w[g] = bus[g].rd_count_o;
    assign wrc_w[g] = bus[g].wr_count_o;

    dma_ext_mem_responder #(.RD_LATENCY(LAT[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares every valid beat against the front of that instance's scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld_w[k]) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("L%0d unexpected_valid", LAT[k]), 32'd1, 32'd0);
        end else begin
          e_m = sb[k].pop_front();
          chk($sformatf("L%0d rd_data", LAT[k]), dat_w[k], e_m.data);
          chk($sformatf("L%0d rd_cycle", LAT[k]), 32'(cyc), 32'(e_m.due));
        end
      end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
        e_m = sb[k].pop_front();
        chk($sformatf("L%0d missing_valid", LAT[k]), 32'd0, 32'd1);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rs);
    logic [31:0] off;
    logic        win;
    exp_t        e;
    rd_req = r; wr_req = w; addr = a; wr_data = d; rst = rs;
    off = a - BASE;
    win = off < 32'd1024;
    @(posedge clk);
    #1;
    if (rs) begin
      for (int k = 0; k < 3; k++) sb[k].delete();
      exp_rd = '0; exp_wr = '0; exp_err = 1'b0;
    end else begin
      if (w && win) mdl[off[9:2]] = d;
      if (r) begin
        for (int k = 0; k < 3; k++) begin
          e.data = win ? mdl[off[9:2]] : ERRD;
          e.due  = cyc + LAT[k] - 1;
          sb[k].push_back(e);
        end
        if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
      end
      if (w && exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
      if ((r || w) && !win) exp_err = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_status(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d rd_count", tag, LAT[k]), 32'(rdc_w[k]), 32'(exp_rd));
      chk($sformatf("%s L%0d wr_count", tag, LAT[k]), 32'(wrc_w[k]), 32'(exp_wr));
      chk($sformatf("%s L%0d err", tag, LAT[k]), 32'(err_w[k]), 32'(exp_err));
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d rd_valid", tag, LAT[k]), 32'(vld_w[k]), 32'(v));
      chk($sformatf("%s L%0d rd_data", tag, LAT[k]), dat_w[k], d);
    end
  endtask

  initial begin
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    check_out("reset", 1'b0, 32'h0);
    check_status("reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset L%0d count_zero", LAT[k]), 32'(rdc_w[k]), 32'd0);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, BASE + 32'(i * 4), 32'hBEEF_0001 + 32'(i), 1'b0);
    check_status("preload");
    chk("preload wr_count", 32'(wrc_w[0]), 32'd4);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, BASE + 32'(i * 4), '0, 1'b0);
    idle(10);
    check_out("burst_hold", 1'b0, 32'hBEEF_0004);
    check_status("burst");
    chk("burst rd_count", 32'(rdc_w[0]), 32'd4);

    drive(1'b1, 1'b0, 32'h1000_0003, '0, 1'b0);
    drive(1'b1, 1'b0, 32'h0FFF_FFFC, '0, 1'b0);
    drive(1'b1, 1'b0, 32'h1000_0400, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h1000_0400, 32'h5555_AAAA, 1'b0);
    drive(1'b1, 1'b0, 32'h1000_0000, '0, 1'b0);
    idle(10);
    check_status("window");
    chk("window err_sticky", 32'(err_w[0]), 32'd1);

    drive(1'b1, 1'b1, 32'h1000_0008, 32'h1234_5678, 1'b0);
    idle(10);
    check_out("same_cycle", 1'b0, 32'h1234_5678);
    check_status("same_cycle");

    drive(1'b1, 1'b0, 32'h1000_0000, '0, 1'b0);
    drive(1'b1, 1'b0, 32'h1000_0004, '0, 1'b0);
    drive(1'b0, 1'b1, 32'h1000_0004, 32'h0BAD_0BAD, 1'b1);
    check_out("mid_reset", 1'b0, 32'h0);
    check_status("mid_reset");
    idle(10);
    drive(1'b1, 1'b0, 32'h1000_0004, '0, 1'b0);
    idle(10);
    check_out("retained", 1'b0, 32'hBEEF_0002);
    check_status("retained");

    for (int i = 0; i < 70000; i++) drive(1'b0, 1'b1, BASE + 32'((i % 256) * 4), 32'(i), 1'b0);
    check_status("saturate");
    for (int k = 0; k < 3; k++) chk($sformatf("saturate L%0d wr_count", LAT[k]), 32'(wrc_w[k]), 32'h0000_FFFF);

    idle(4);
    for (int k = 0; k < 3; k++) chk($sformatf("drain L%0d pending", LAT[k]), 32'(sb[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_ext_mem_responder.md
Name: dma_ext_mem_responder

Overview:
- External-memory responder at the far end of the DMA read/write interface.
- Services DMA read requests (address in, data returned after a fixed latency) and DMA write requests (address plus data in, committed to an internal word array).
- Used as the memory model in dma-level benches and as an on-chip scratch memory behind the DMA in integration builds.
- Counts transactions and flags out-of-window accesses.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of 2, 4..4096).
- BASE_ADDR, 32'h1000_0000, byte address of word 0.
- RD_LATENCY, 2, cycles from an accepted read to rd_valid_o (1..8).
- ERR_DATA, 32'hDEAD_BEEF, value returned for out-of-window reads.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_req_i  in  1  read request, one word per cycle; driven by DMA data_req_o.
- wr_req_i  in  1  write request, one word per cycle; driven by DMA write_req_o.
- addr_i  in  32  byte address for the request; driven by DMA external_addr.
- wr_data_i  in  32  write data; driven by DMA write_data_o.
- rd_data_o  out  32  read data; feeds DMA store_data.
- rd_valid_o  out  1  rd_data_o valid for this cycle.
- err_o  out  1  sticky out-of-window flag.
- rd_count_o  out  16  accepted reads since reset.
- wr_count_o  out  16  accepted writes since reset.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - rd_data_o=0, rd_valid_o=0, err_o=0, rd_count_o=0, wr_count_o=0.
  - Latency pipeline cleared, so any in-flight reads are discarded and produce no rd_valid_o afterwards.
  - Array contents are not cleared.
- Address decode:
  - off = addr_i - BASE_ADDR, computed modulo 2^32.
  - Index = off[log2(DEPTH)+1:2]; addr_i[1:0] is ignored.
  - In-window when off < DEPTH*4 (unsigned). Addresses below BASE_ADDR wrap to a large off and are out-of-window.
- Read path:
  - rd_req_i=1 is always accepted; there is no backpressure and back-to-back requests every cycle are supported.
  - Array sampled at the accept edge; result enters a RD_LATENCY-deep valid/data shift pipeline.
  - rd_valid_o/rd_data_o appear exactly RD_LATENCY cycles after the accepting edge, in request order.
  - When rd_valid_o=0, rd_data_o holds its last value (0 after reset).
  - Out-of-window read: the result is ERR_DATA, rd_valid_o is still asserted, and err_o is set at the accept edge.
- Write path:
  - wr_req_i=1 writes wr_data_i to array[index] at the same edge.
  - Out-of-window write: array untouched, err_o set.
- Simultaneous rd_req_i and wr_req_i in the same cycle:
  - Both accepted, both use addr_i.
  - Write-first: the read returns wr_data_i.
  - Both counters increment.
- Read of an address written in an earlier cycle returns the newest data. There is no hazard window, because reads sample the array at accept.
- Counters increment on every accepted request, including out-of-window ones. They saturate at 16'hFFFF and do not wrap.
- err_o stays set until rst.
- Reset mid-burst:
  - Pipeline is flushed; the first rd_valid_o after reset comes from a post-reset request only.
  - A write at the same edge as rst=1 is ignored.

Test Plan:
1. Preload via writes: BEEF_0001..BEEF_0004 to addresses 1000_0000, 1000_0004, 1000_0008, 1000_000C.
   -> wr_count_o=4, err_o=0.
2. Four back-to-back reads, 1000_0000..1000_000C, RD_LATENCY=2.
   -> rd_valid_o high on cycles 2..5 after the first request, data BEEF_0001..BEEF_0004 in order, rd_count_o=4.
3. Read 1000_0003 with addr[1:0] nonzero.
   -> returns BEEF_0001. Read 0FFF_FFFC and 1000_0400 (DEPTH=256).
   -> each returns DEAD_BEEF with rd_valid_o=1, err_o=1 and stays high, array unchanged.
4. Same-cycle rd_req_i=wr_req_i=1 at 1000_0008 with data 1234_5678.
   -> read returns 1234_5678 after RD_LATENCY; both counters +1.
5. Issue 2 reads, then assert rst for one cycle on the next edge.
   -> no rd_valid_o after reset, counters 0, err_o 0. A following read of 1000_0004 returns BEEF_0002, showing the array was retained.
6. Sweep RD_LATENCY=1 and 8 with scenario 2.
   -> valid timing shifts accordingly.
   -> With 70000 writes, wr_count_o saturates at FFFF.
